// File: rtl/ofs_pipe_reg_bank.sv
//------------------------------------------------------------------------------
// Module      : ofs_pipe_reg_bank
// Description : WIDTH-bit, DEPTH-stage clock-enabled output register pipeline
//               with per-bit reset value, synchronous local set/reset,
//               valid-tracking shift chain and flush. Keeps data and its
//               qualifier aligned on the way to the output pads.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ofs_pipe_reg_bank #(
  parameter int                WIDTH   = 8,
  parameter int                DEPTH   = 2,
  parameter logic [WIDTH-1:0]  INIT    = {WIDTH{1'b1}},
  parameter string             LSRMODE = "CE_GATED"
) (
  input  logic             SCLK,
  input  logic             GSRN,
  input  logic             SP,
  input  logic             LSR,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic             BUSY
);

  // "DIRECT" lets LSR act without the clock enable; otherwise it is gated by SP
  localparam bit c_lsr_direct = (LSRMODE == "DIRECT");

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic             lsr_hit;

  assign lsr_hit = LSR & (c_lsr_direct | SP);

  // Next-state: LSR beats FLUSH; FLUSH clears valids but lets data shift on SP
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (lsr_hit) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_d[k] = INIT;
      end
      vld_d = '0;
    end else begin
      if (SP) begin
        data_d[0] = D;
        vld_d[0]  = DV;
        for (int k = 1; k < DEPTH; k++) begin
          data_d[k] = data_q[k-1];
          vld_d[k]  = vld_q[k-1];
        end
      end
      if (FLUSH) begin
        vld_d = '0;
      end
    end
  end

  // State registers; GSRN clears everything without needing a clock edge
  always_ff @(posedge SCLK or negedge GSRN) begin
    if (!GSRN) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= INIT;
      end
      vld_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
      vld_q <= vld_d;
    end
  end

  // Outputs come straight from state, so no input-to-output combinational path
  assign Q    = data_q[DEPTH-1];
  assign QV   = vld_q[DEPTH-1];
  assign BUSY = |vld_q;

endmodule

`default_nettype wire

// File: tb/tb_ofs_pipe_reg_bank.sv
//------------------------------------------------------------------------------
// Module      : tb_ofs_pipe_reg_bank
// Description : Directed, table-driven bench for ofs_pipe_reg_bank. Three
//               instances: A (DEPTH=3, CE_GATED), B (DEPTH=3, DIRECT),
//               C (DEPTH=8, CE_GATED).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ofs_pipe_reg_bank;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic gsrn;

  logic       a_sp, a_lsr, a_flush, a_dv;
  logic [7:0] a_d, a_q;
  logic       a_qv, a_busy;

  logic       b_sp, b_lsr, b_flush, b_dv;
  logic [7:0] b_d, b_q;
  logic       b_qv, b_busy;

  logic       c_sp, c_lsr, c_flush, c_dv;
  logic [7:0] c_d, c_q;
  logic       c_qv, c_busy;

  ofs_pipe_reg_bank #(.WIDTH(8), .DEPTH(3), .INIT(8'hA5), .LSRMODE("CE_GATED")) u_a (
    .SCLK(sclk), .GSRN(gsrn), .SP(a_sp), .LSR(a_lsr), .FLUSH(a_flush),
    .D(a_d), .DV(a_dv), .Q(a_q), .QV(a_qv), .BUSY(a_busy)
  );

  ofs_pipe_reg_bank #(.WIDTH(8), .DEPTH(3), .INIT(8'hA5), .LSRMODE("DIRECT")) u_b (
    .SCLK(sclk), .GSRN(gsrn), .SP(b_sp), .LSR(b_lsr), .FLUSH(b_flush),
    .D(b_d), .DV(b_dv), .Q(b_q), .QV(b_qv), .BUSY(b_busy)
  );

  ofs_pipe_reg_bank #(.WIDTH(8), .DEPTH(8), .INIT(8'h3C), .LSRMODE("CE_GATED")) u_c (
    .SCLK(sclk), .GSRN(gsrn), .SP(c_sp), .LSR(c_lsr), .FLUSH(c_flush),
    .D(c_d), .DV(c_dv), .Q(c_q), .QV(c_qv), .BUSY(c_busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       sp;
    logic       lsr;
    logic       flush;
    logic [7:0] d;
    logic       dv;
    logic [7:0] q;
    logic       qv;
    logic       busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic sp, input logic lsr, input logic flush,
                     input logic [7:0] d, input logic dv,
                     input logic [7:0] q, input logic qv, input logic busy);
    vec_t v;
    v.sp = sp; v.lsr = lsr; v.flush = flush; v.d = d; v.dv = dv;
    v.q = q; v.qv = qv; v.busy = busy;
    vq.push_back(v);
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  initial begin
    gsrn = 1'b1;
    a_sp = 0; a_lsr = 0; a_flush = 0; a_d = 8'h00; a_dv = 0;
    b_sp = 0; b_lsr = 0; b_flush = 0; b_d = 8'h00; b_dv = 0;
    c_sp = 0; c_lsr = 0; c_flush = 0; c_d = 8'h00; c_dv = 0;

    // Asynchronous reset between clock edges (first posedge is at t=5)
    #2 gsrn = 1'b0;
    #1;
    chk8("rst_a_q", a_q, 8'hA5);  chk1("rst_a_qv", a_qv, 1'b0);  chk1("rst_a_busy", a_busy, 1'b0);
    chk8("rst_b_q", b_q, 8'hA5);  chk1("rst_b_qv", b_qv, 1'b0);  chk1("rst_b_busy", b_busy, 1'b0);
    chk8("rst_c_q", c_q, 8'h3C);  chk1("rst_c_qv", c_qv, 1'b0);  chk1("rst_c_busy", c_busy, 1'b0);
    #1 gsrn = 1'b1;

    // ---- table for instance A: sp lsr flush d dv | q qv busy ----
    for (int i = 0; i < 5; i++) add(0, 0, 0, 8'hFF, 1, 8'hA5, 0, 0); // SP=0 hold after reset
    // stream 1..4, then DV=0
    add(1, 0, 0, 8'h01, 1, 8'hA5, 0, 1);
    add(1, 0, 0, 8'h02, 1, 8'hA5, 0, 1);
    add(1, 0, 0, 8'h03, 1, 8'h01, 1, 1);
    add(1, 0, 0, 8'h04, 1, 8'h02, 1, 1);
    add(1, 0, 0, 8'hEE, 0, 8'h03, 1, 1);
    add(1, 0, 0, 8'hEE, 0, 8'h04, 1, 1);
    add(1, 0, 0, 8'hEE, 0, 8'hEE, 0, 0);
    // stall stream: SP=0 on cycles 2 and 4
    add(1, 0, 0, 8'h01, 1, 8'hEE, 0, 1);
    add(0, 0, 0, 8'h55, 1, 8'hEE, 0, 1);
    add(1, 0, 0, 8'h02, 1, 8'hEE, 0, 1);
    add(0, 0, 0, 8'h55, 1, 8'hEE, 0, 1);
    add(1, 0, 0, 8'h03, 1, 8'h01, 1, 1);
    add(1, 0, 0, 8'h04, 1, 8'h02, 1, 1);
    add(1, 0, 0, 8'h66, 0, 8'h03, 1, 1);
    add(0, 0, 0, 8'h77, 1, 8'h03, 1, 1);
    add(1, 0, 0, 8'h77, 0, 8'h04, 1, 1);
    add(1, 0, 0, 8'h77, 0, 8'h66, 0, 0);
    // fill, then CE_GATED LSR with SP=0 is ignored (FLUSH still applies)
    add(1, 0, 0, 8'h11, 1, 8'h77, 0, 1);
    add(1, 0, 0, 8'h22, 1, 8'h77, 0, 1);
    add(1, 0, 0, 8'h33, 1, 8'h11, 1, 1);
    add(0, 1, 0, 8'h44, 1, 8'h11, 1, 1);
    add(0, 1, 1, 8'h44, 1, 8'h11, 0, 0);
    // refill, then LSR with SP=1 restores INIT
    add(1, 0, 0, 8'hAA, 1, 8'h22, 0, 1);
    add(1, 0, 0, 8'hBB, 1, 8'h33, 0, 1);
    add(1, 0, 0, 8'hCC, 1, 8'hAA, 1, 1);
    add(1, 1, 0, 8'hDD, 1, 8'hA5, 0, 0);
    // refill, FLUSH alone with SP=0 keeps data
    add(1, 0, 0, 8'h01, 1, 8'hA5, 0, 1);
    add(1, 0, 0, 8'h02, 1, 8'hA5, 0, 1);
    add(1, 0, 0, 8'h03, 1, 8'h01, 1, 1);
    add(0, 0, 1, 8'hFF, 1, 8'h01, 0, 0);
    // refill, FLUSH with SP=1 shifts data but leaves everything invalid
    add(1, 0, 0, 8'h04, 1, 8'h02, 0, 1);
    add(1, 0, 0, 8'h05, 1, 8'h03, 0, 1);
    add(1, 0, 0, 8'h06, 1, 8'h04, 1, 1);
    add(1, 0, 1, 8'h07, 1, 8'h05, 0, 0);
    // FLUSH and LSR together: LSR wins
    add(1, 1, 1, 8'h08, 1, 8'hA5, 0, 0);

    foreach (vq[i]) begin
      a_sp = vq[i].sp; a_lsr = vq[i].lsr; a_flush = vq[i].flush;
      a_d = vq[i].d;   a_dv = vq[i].dv;
      tick();
      chk8($sformatf("a_q[%0d]", i), a_q, vq[i].q);
      chk1($sformatf("a_qv[%0d]", i), a_qv, vq[i].qv);
      chk1($sformatf("a_busy[%0d]", i), a_busy, vq[i].busy);
    end
    a_sp = 0; a_lsr = 0; a_flush = 0; a_dv = 0;

    // ---- instance B: DIRECT mode LSR acts with SP=0 ----
    b_sp = 1; b_dv = 1; b_d = 8'h5A;
    tick(); tick(); tick();
    chk8("b_fill_q", b_q, 8'h5A); chk1("b_fill_qv", b_qv, 1'b1); chk1("b_fill_busy", b_busy, 1'b1);
    b_sp = 0; b_lsr = 1;
    tick();
    chk8("b_lsr_q", b_q, 8'hA5); chk1("b_lsr_qv", b_qv, 1'b0); chk1("b_lsr_busy", b_busy, 1'b0);
    b_lsr = 0; b_dv = 0;

    // ---- instance C: DEPTH=8, mid-stream reset then full-latency restart ----
    c_sp = 1; c_dv = 1;
    for (int i = 0; i < 5; i++) begin
      c_d = 8'h10 + 8'(i);
      tick();
      chk1($sformatf("c_pre_qv[%0d]", i), c_qv, 1'b0);
      chk1($sformatf("c_pre_busy[%0d]", i), c_busy, 1'b1);
    end
    #2 gsrn = 1'b0;
    #0.5;
    chk8("c_mid_rst_q", c_q, 8'h3C); chk1("c_mid_rst_qv", c_qv, 1'b0); chk1("c_mid_rst_busy", c_busy, 1'b0);
    #0.5 gsrn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      c_d = 8'h20 + 8'(i);
      tick();
      if (i < 7) begin
        chk1($sformatf("c_restart_qv[%0d]", i), c_qv, 1'b0);
      end else begin
        chk8($sformatf("c_restart_q[%0d]", i), c_q, 8'h20 + 8'(i - 7));
        chk1($sformatf("c_restart_qv[%0d]", i), c_qv, 1'b1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ofs_pipe_reg_bank.md
# ofs_pipe_reg_bank

Parametrised output-register bank for the ECP5 I/O path. It generalises the single-bit, preset-only output flip-flop to WIDTH bits and a DEPTH-stage clock-enabled pipeline. Each bit has its own reset value. It adds a selectable synchronous local set/reset, a valid-tracking shift chain and a flush. It sits between core logic and the output pads so that data and its qualifier leave the fabric aligned on the same edge.

## Interface
- WIDTH, 8, data bits per stage (1..64)
- DEPTH, 2, pipeline stages (1..8); total latency in enabled cycles
- INIT, {WIDTH{1'b1}}, per-bit reset/set value; 1 = preset, 0 = clear
- LSRMODE, "CE_GATED", "CE_GATED": LSR acts only when SP=1; "DIRECT": LSR acts regardless of SP

- SCLK  in  1  clock, all state rising-edge
- GSRN  in  1  asynchronous active-low reset, whole bank
- SP  in  1  clock enable for every stage
- LSR  in  1  synchronous local set/reset, active high
- FLUSH  in  1  synchronous invalidate of all stages, active high
- D  in  WIDTH  data into stage 0
- DV  in  1  qualifier for D
- Q  out  WIDTH  data of last stage (stage DEPTH-1)
- QV  out  1  qualifier of last stage
- BUSY  out  1  OR of all stage valid bits

## Operation
- State: data[0..DEPTH-1] (WIDTH each), vld[0..DEPTH-1] (1 each).
- GSRN=0: asynchronously data[k]=INIT and vld[k]=0 for all k, with no clock needed. On release, the first effective edge is the first rising SCLK after deassertion.
- Per rising edge with GSRN=1, first matching rule wins:
  1. LSR=1 and (LSRMODE="DIRECT" or SP=1): all data[k]=INIT, all vld[k]=0.
  2. FLUSH=1: all vld[k]=0, data held; if SP=1 the shift below still moves data, and vld stays 0 everywhere.
  3. SP=1: data[0]<=D, vld[0]<=DV; data[k]<=data[k-1], vld[k]<=vld[k-1] for k≥1.
  4. SP=0: hold everything.
- In "CE_GATED" mode, LSR=1 with SP=0 is ignored and rules 2 and 4 apply.
- Data shifts on SP regardless of DV. DV only qualifies the data, so invalid words still occupy stages.
- DEPTH=1 degenerates to a single register bank: Q=data[0].
- Q=data[DEPTH-1], QV=vld[DEPTH-1], BUSY=|vld. All are registered or derived from registers; no path from D, DV or SP to outputs.
- X on SP or LSR must not corrupt GSRN behaviour. GSRN asserted mid-pipeline discards all in-flight words.

## Timing
- Reset values: Q=INIT, QV=0, BUSY=0.
- Latency: a word presented with SP=1 at edge n appears on Q/QV after the DEPTH-th SP=1 edge counting from n. With SP held high, it is visible DEPTH cycles later.
- SP=0 cycles stretch latency one-for-one. No word is lost or duplicated.
- LSR or FLUSH take effect at the edge where they are sampled. Q/QV/BUSY reflect the new state immediately after that edge.
- LSR and FLUSH together: LSR dominates, giving data=INIT and vld=0.
- GSRN assertion: outputs change asynchronously. Deassertion should be synchronised upstream; the block is not required to tolerate recovery/removal violations.
- BUSY falls the edge after the last valid word shifts out of stage DEPTH-1, or on the FLUSH/LSR edge.

## Test plan
- Reset: WIDTH=8, INIT=8'hA5, DEPTH=3; pulse GSRN low mid-clock -> Q=8'hA5, QV=0, BUSY=0 with no SCLK edge; after release, hold SP=0 for 5 cycles -> unchanged.
- Latency/stream: DEPTH=3, SP=1, D=1,2,3,4 with DV=1 -> Q=1 with QV=1 on the 3rd edge after the first word, then 2, 3, 4 on consecutive edges; BUSY drops 3 edges after DV goes 0.
- Stall: same stream with SP=0 on cycles 2 and 4 -> latency 5 edges for word 1, order 1,2,3,4 preserved, no repeats.
- LSR modes: "CE_GATED", LSR=1 with SP=0 -> no change; with SP=1 -> Q=INIT, QV=0. "DIRECT", LSR=1 with SP=0 -> Q=INIT, QV=0 on that edge.
- Flush vs LSR: pipeline full of valid words; FLUSH=1 alone -> QV=0 and BUSY=0 next edge, Q data retained. FLUSH=1 with LSR=1 -> Q=INIT.
- Mid-operation reset: DEPTH=8, stream running, GSRN low for 1 ns -> all outputs reset immediately; the next stream restarts with full 8-edge latency.
